// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and widths for the conv engine MAC sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int OPND_W    = 8;
    localparam int PROD_W    = 16;
    localparam int TAPS_W    = 8;
    localparam int ACC_W_DEF = 24;
    localparam int OUT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } conv_state_e;

endpackage

`default_nettype wire

// File: rtl/conv_mac_ctrl_if.sv
// ============================================================================
// Module   : conv_mac_ctrl_if
// Brief    : Control, tap-stream and result handshake bundle of conv_mac_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface conv_mac_ctrl_if
    import conv_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
);

    logic                      start;
    logic [TAPS_W-1:0]         cfg_taps;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [OPND_W-1:0]  in_a;
    logic signed [OPND_W-1:0]  in_d;
    logic signed [OPND_W-1:0]  in_b;
    logic                      res_valid;
    logic                      res_ready;
    logic signed [OUT_W-1:0]   res_ab;
    logic signed [OUT_W-1:0]   res_db;
    logic                      done;

    modport master (
        output start, cfg_taps, in_valid, in_a, in_d, in_b, res_ready,
        input  busy, in_ready, res_valid, res_ab, res_db, done
    );

    modport slave (
        input  start, cfg_taps, in_valid, in_a, in_d, in_b, res_ready,
        output busy, in_ready, res_valid, res_ab, res_db, done
    );

endinterface

`default_nettype wire

// File: rtl/conv_mult_dsp.sv
// ============================================================================
// Module   : conv_mult_dsp
// Brief    : Packed dual int8 multiplier, a*b and d*b, LAT-stage pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_mult_dsp
    import conv_pkg::*;
#(
    parameter int LAT = 3
) (
    input  wire                       clk,
    input  wire                       rst_n,
    input  wire signed [OPND_W-1:0]   a_i,
    input  wire signed [OPND_W-1:0]   d_i,
    input  wire signed [OPND_W-1:0]   b_i,
    output logic signed [PROD_W-1:0]  data_ab_o,
    output logic signed [PROD_W-1:0]  data_db_o
);

    logic signed [PROD_W-1:0] ab_q [LAT];
    logic signed [PROD_W-1:0] db_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                ab_q[i] <= '0;
                db_q[i] <= '0;
            end
        end else begin
            ab_q[0] <= PROD_W'(a_i) * PROD_W'(b_i);
            db_q[0] <= PROD_W'(d_i) * PROD_W'(b_i);
            for (int i = 1; i < LAT; i++) begin
                ab_q[i] <= ab_q[i-1];
                db_q[i] <= db_q[i-1];
            end
        end
    end

    assign data_ab_o = ab_q[LAT-1];
    assign data_db_o = db_q[LAT-1];

endmodule

`default_nettype wire

// File: rtl/conv_mac_ctrl.sv
// ============================================================================
// Module   : conv_mac_ctrl
// Brief    : Sequences conv_mult_dsp over a tap window and returns two sums.
//            CONV_MAC_SAT_EN selects saturating results instead of wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_mac_ctrl
    import conv_pkg::*;
#(
    parameter int MULT_LAT = 3,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  wire            sclk,
    input  wire            s_rst_n,
    conv_mac_ctrl_if.slave bus
);

    localparam logic signed [ACC_W-1:0] C_OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    conv_state_e              state_q;
    logic [TAPS_W-1:0]        taps_q;
    logic [TAPS_W-1:0]        cnt_q;
    logic [MULT_LAT-1:0]      tag_q;
    logic                     prod_vld_q;
    logic signed [PROD_W-1:0] prod_ab_q;
    logic signed [PROD_W-1:0] prod_db_q;
    logic signed [ACC_W-1:0]  acc_ab_q;
    logic signed [ACC_W-1:0]  acc_db_q;
    logic signed [OUT_W-1:0]  res_ab_q;
    logic signed [OUT_W-1:0]  res_db_q;
    logic                     busy_q;
    logic                     in_ready_q;
    logic                     res_valid_q;
    logic                     done_q;

    logic                     beat_d;
    logic signed [OPND_W-1:0] mul_a_d;
    logic signed [OPND_W-1:0] mul_d_d;
    logic signed [OPND_W-1:0] mul_b_d;
    logic signed [PROD_W-1:0] data_ab;
    logic signed [PROD_W-1:0] data_db;

    function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] v);
`ifdef CONV_MAC_SAT_EN
        if (v > C_OUT_MAX) begin
            return OUT_W'(C_OUT_MAX);
        end else if (v < C_OUT_MIN) begin
            return OUT_W'(C_OUT_MIN);
        end
        return OUT_W'(v);
`else
        return OUT_W'(v);
`endif
    endfunction

    // in_ready_q is only ever high in ISSUE, so a beat implies ISSUE.
    assign beat_d  = bus.in_valid & in_ready_q;
    assign mul_a_d = beat_d ? bus.in_a : '0;
    assign mul_d_d = beat_d ? bus.in_d : '0;
    assign mul_b_d = beat_d ? bus.in_b : '0;

    conv_mult_dsp #(
        .LAT       (MULT_LAT)
    ) u_mult (
        .clk       (sclk),
        .rst_n     (s_rst_n),
        .a_i       (mul_a_d),
        .d_i       (mul_d_d),
        .b_i       (mul_b_d),
        .data_ab_o (data_ab),
        .data_db_o (data_db)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            prod_vld_q  <= 1'b0;
            prod_ab_q   <= '0;
            prod_db_q   <= '0;
            acc_ab_q    <= '0;
            acc_db_q    <= '0;
            res_ab_q    <= '0;
            res_db_q    <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tag_q      <= (tag_q << 1) | MULT_LAT'(beat_d);
            prod_vld_q <= tag_q[MULT_LAT-1];
            prod_ab_q  <= data_ab;
            prod_db_q  <= data_db;
            done_q     <= 1'b0;

            if (prod_vld_q) begin
                acc_ab_q <= acc_ab_q + ACC_W'(prod_ab_q);
                acc_db_q <= acc_db_q + ACC_W'(prod_db_q);
            end

            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.cfg_taps != '0)) begin
                        taps_q     <= bus.cfg_taps;
                        cnt_q      <= '0;
                        acc_ab_q   <= '0;
                        acc_db_q   <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (beat_d) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == taps_q - 8'd1) begin
                            in_ready_q <= 1'b0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Both the tag pipe and the accumulate stage must be empty.
                    if ((tag_q == '0) && !prod_vld_q) begin
                        res_ab_q    <= fit_out(acc_ab_q);
                        res_db_q    <= fit_out(acc_db_q);
                        res_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ab    = res_ab_q;
    assign bus.res_db    = res_db_q;
    assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_ctrl.sv
// ============================================================================
// Module   : tb_conv_mac_ctrl
// Brief    : Self-checking bench for conv_mac_ctrl (honours CONV_MAC_SAT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_mac_ctrl;

    localparam int MULT_LAT = 3;
    localparam int P_IDLE   = 0;
    localparam int P_ISSUE  = 1;
    localparam int P_DRAIN  = 2;
    localparam int P_OUT    = 3;

    logic sclk;
    logic s_rst_n;

    conv_mac_ctrl_if #(.OUT_W(16)) bus ();

    conv_mac_ctrl #(
        .MULT_LAT (MULT_LAT),
        .ACC_W    (24),
        .OUT_W    (16)
    ) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .bus      (bus)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    // Window model: phase, running sums, and the edge at which the result appears.
    int m_phase, m_taps, m_cnt, m_cyc, m_rdy;
    int m_sum_ab, m_sum_db, m_res_ab, m_res_db;
    bit m_done;

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    function automatic int fit(input int v);
`ifdef CONV_MAC_SAT_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
`endif
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #2;
    endtask

    function automatic logic signed [7:0] pick(input bit extreme);
        if (extreme) return ($urandom_range(1) == 1) ? 8'sd127 : -8'sd128;
        return 8'($urandom);
    endfunction

    initial begin
        m_phase = P_IDLE; m_taps = 0; m_cnt = 0; m_cyc = 0; m_rdy = 0;
        m_sum_ab = 0; m_sum_db = 0; m_res_ab = 0; m_res_db = 0; m_done = 1'b0;
        forever begin
            @(posedge sclk or negedge s_rst_n);
            if (!s_rst_n) begin
                m_phase = P_IDLE;
                m_done  = 1'b0;
            end else begin
                m_cyc++;
                m_done = 1'b0;
                case (m_phase)
                    P_IDLE: if (bus.start && bus.cfg_taps != 0) begin
                        m_taps = int'(bus.cfg_taps); m_cnt = 0;
                        m_sum_ab = 0; m_sum_db = 0; m_phase = P_ISSUE;
                    end
                    P_ISSUE: if (bus.in_valid) begin
                        m_sum_ab += int'(bus.in_a) * int'(bus.in_b);
                        m_sum_db += int'(bus.in_d) * int'(bus.in_b);
                        m_cnt++;
                        if (m_cnt == m_taps) begin
                            m_phase = P_DRAIN;
                            m_rdy   = m_cyc + MULT_LAT + 2;
                        end
                    end
                    P_DRAIN: if (m_cyc == m_rdy) begin
                        m_res_ab = fit(m_sum_ab);
                        m_res_db = fit(m_sum_db);
                        m_phase  = P_OUT;
                    end
                    default: if (bus.res_ready) begin
                        m_phase = P_IDLE;
                        m_done  = 1'b1;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge sclk);
            if (s_rst_n) begin
                if (bus.done) n_done++;
                check("busy",      32'(bus.busy),      32'(m_phase != P_IDLE));
                check("in_ready",  32'(bus.in_ready),  32'(m_phase == P_ISSUE));
                check("res_valid", 32'(bus.res_valid), 32'(m_phase == P_OUT));
                check("done",      32'(bus.done),      32'(m_done));
                if (m_phase == P_OUT) begin
                    check("res_ab", 32'(bus.res_ab), m_res_ab);
                    check("res_db", 32'(bus.res_db), m_res_db);
                end
            end
        end
    end

    task automatic directed(input int taps, input int gap_at, input int gap_len, input int bp,
                            input logic signed [7:0] a, input logic signed [7:0] d, input logic signed [7:0] b,
                            output int lat, output int rab, output int rdb, output int ndone);
        int beats, g, d0;
        d0 = n_done;
        bus.start = 1'b1; bus.cfg_taps = 8'(taps);
        tick();
        bus.start = 1'b0;
        bus.in_a = a; bus.in_d = d; bus.in_b = b;
        beats = 0; g = 0; lat = 0;
        while (beats < taps) begin
            if (beats == gap_at && g < gap_len) begin
                bus.in_valid = 1'b0; g++;
            end else begin
                bus.in_valid = 1'b1; beats++;
            end
            tick(); lat++;
        end
        bus.in_valid = 1'b0;
        while (!bus.res_valid && lat < 400) begin
            tick(); lat++;
        end
        rab = int'(bus.res_ab);
        rdb = int'(bus.res_db);
        repeat (bp) tick();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        repeat (2) tick();
        ndone = n_done - d0;
    endtask

    task automatic rand_window(input int taps, input int gap_pct, input int bp_pct, input bit extreme);
        int budget;
        bus.start = 1'b1; bus.cfg_taps = 8'(taps);
        tick();
        budget = 0;
        do begin
            bus.in_valid  = ($urandom_range(99) >= gap_pct);
            bus.in_a      = pick(extreme);
            bus.in_d      = pick(extreme);
            bus.in_b      = pick(extreme);
            bus.res_ready = ($urandom_range(99) >= bp_pct);
            bus.start     = ($urandom_range(19) == 0);
            bus.cfg_taps  = 8'($urandom_range(255));
            tick();
            budget++;
        end while (!bus.done && budget < 3000);
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        if (!bus.done) begin
            n_cmp++; n_err++;
            $display("FAIL window_timeout: got no done within %0d cycles, expected done", budget);
        end
        tick();
    endtask

    initial begin
        int lat, rab, rdb, nd, ea, ed;
        s_rst_n = 1'b0;
        bus.start = 1'b0; bus.cfg_taps = '0; bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_d = '0; bus.in_b = '0; bus.res_ready = 1'b0;
        repeat (2) @(posedge sclk);
        #2;
        check("rst_busy",      32'(bus.busy),      0);
        check("rst_in_ready",  32'(bus.in_ready),  0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_done",      32'(bus.done),      0);
        check("rst_res_ab",    32'(bus.res_ab),    0);
        check("rst_res_db",    32'(bus.res_db),    0);
        s_rst_n = 1'b1;
        tick();

        directed(1, -1, 0, 0, 8'sd3, -8'sd2, 8'sd5, lat, rab, rdb, nd);
        check("t1_latency", lat, 1 + MULT_LAT + 2);
        check("t1_res_ab", rab, 15);
        check("t1_res_db", rdb, -10);
        check("t1_done_cnt", nd, 1);

`ifdef CONV_MAC_SAT_EN
        ea = -32768; ed = 32767;
`else
        ea = -15232; ed = 16384;
`endif
        directed(9, -1, 0, 1, 8'sd127, -8'sd128, -8'sd128, lat, rab, rdb, nd);
        check("t2_latency", lat, 9 + MULT_LAT + 2);
        check("t2_res_ab", rab, ea);
        check("t2_res_db", rdb, ed);

        directed(4, 2, 2, 5, 8'sd3, 8'sd4, -8'sd6, lat, rab, rdb, nd);
        check("t4_latency", lat, 4 + 2 + MULT_LAT + 2);
        check("t4_res_ab", rab, -72);
        check("t4_res_db", rdb, -96);
        check("t4_done_cnt", nd, 1);

        bus.start = 1'b1; bus.cfg_taps = 8'd0;
        tick();
        bus.start = 1'b0;
        check("t6_zero_taps_busy", 32'(bus.busy), 0);
        tick();
        check("t6_zero_taps_ready", 32'(bus.in_ready), 0);

        bus.start = 1'b1; bus.cfg_taps = 8'd9;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'sd5; bus.in_d = 8'sd5; bus.in_b = 8'sd5;
        repeat (3) tick();
        s_rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("t5_rst_busy",      32'(bus.busy),      0);
        check("t5_rst_in_ready",  32'(bus.in_ready),  0);
        check("t5_rst_res_valid", 32'(bus.res_valid), 0);
        check("t5_rst_res_ab",    32'(bus.res_ab),    0);
        #1;
        s_rst_n = 1'b1;
        tick();
        directed(1, -1, 0, 0, 8'sd1, 8'sd1, 8'sd1, lat, rab, rdb, nd);
        check("t5_latency", lat, 1 + MULT_LAT + 2);
        check("t5_res_ab", rab, 1);
        check("t5_res_db", rdb, 1);

        for (int w = 0; w < 40; w++) begin
            rand_window(int'($urandom_range(12, 1)), int'($urandom_range(40)),
                        int'($urandom_range(50)), ($urandom_range(3) == 0));
        end
        rand_window(255, 10, 20, 1'b1);
        rand_window(255, 25, 40, 1'b0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
